// File: rtl/rtcl_hs_tx_framer_if.sv
// Handshake bundle between the upstream beat source, the framer and the D-PHY PPI TX side.
// The framer is the slave; the stream source / PHY model is the master.
interface rtcl_hs_tx_framer_if #(
    parameter int unsigned DPHY_LANES = 2
);
    localparam int unsigned W = DPHY_LANES * 8;

    logic         s_first;
    logic         s_last;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         tx_request;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic [15:0]  frame_count;
    logic         underrun;
    logic         busy;

    modport master (
        output s_first, s_last, s_data, s_valid, tx_ready,
        input  s_ready, tx_request, tx_data, frame_count, underrun, busy
    );

    modport slave (
        input  s_first, s_last, s_data, s_valid, tx_ready,
        output s_ready, tx_request, tx_data, frame_count, underrun, busy
    );
endinterface

// File: rtl/rtcl_hs_tx_framer.sv
// D-PHY HS burst framer: wraps each upstream frame as header, payload beats and a beat-count
// trailer, then holds tx_request low for a fixed inter-burst gap.
module rtcl_hs_tx_framer #(
    parameter int unsigned DPHY_LANES = 2,
    parameter int unsigned GAP_CYCLES = 8
) (
    input logic clk,
    input logic reset,
    rtcl_hs_tx_framer_if.slave bus
);
    localparam int unsigned W    = DPHY_LANES * 8;
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StTrailer,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic              tx_request_q, tx_request_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [W-1:0]      tx_data;
    logic              s_ready;
    logic              underrun;

    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        beat_cnt_d    = beat_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        tx_data       = '0;
        s_ready       = 1'b0;
        underrun      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A stray beat without s_first is swallowed so we lock onto the next frame.
                if (bus.s_valid) begin
                    if (bus.s_first) begin
                        state_d = StHeader;
                    end else begin
                        s_ready = 1'b1;
                    end
                end
            end
            StHeader: begin
                tx_data = (W'(frame_count_q) << 8) | W'(8'hA5);
                if (bus.tx_ready) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                tx_data = bus.s_valid ? bus.s_data : '0;
                s_ready = bus.tx_ready;
                if (bus.tx_ready) begin
                    // Every PHY-consumed cycle is a beat, including zero fillers.
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    underrun   = ~bus.s_valid;
                    if (bus.s_valid && bus.s_last) begin
                        state_d = StTrailer;
                    end
                end
            end
            StTrailer: begin
                tx_data = W'(beat_cnt_q);
                if (bus.tx_ready) begin
                    state_d       = StGap;
                    frame_count_d = frame_count_q + 16'd1;
                    beat_cnt_d    = '0;
                    gap_cnt_d     = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                    state_d   = StIdle;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        tx_request_d = (state_d == StHeader) || (state_d == StPayload) || (state_d == StTrailer);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tx_request_q  <= 1'b0;
            frame_count_q <= '0;
            beat_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            tx_request_q  <= tx_request_d;
            frame_count_q <= frame_count_d;
            beat_cnt_q    <= beat_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.tx_request  = tx_request_q;
    assign bus.tx_data     = tx_data;
    assign bus.frame_count = frame_count_q;
    assign bus.underrun    = underrun;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_rtcl_hs_tx_framer.sv
// Bench for rtcl_hs_tx_framer: expected HS word stream per frame kept as a queue, checked on
// every cycle, plus literal expectations for the nominal, underrun, wrap and abort cases.
module tb_rtcl_hs_tx_framer;
    localparam int unsigned DPHY_LANES = 2;
    localparam int unsigned GAP        = 8;
    localparam int unsigned W          = DPHY_LANES * 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rtcl_hs_tx_framer_if #(.DPHY_LANES(DPHY_LANES)) bus ();

    rtcl_hs_tx_framer #(
        .DPHY_LANES(DPHY_LANES),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nchk = 0;
    int nfail = 0;

    // Expected words on the HS link; phase 0 header, 1 payload, 2 trailer.
    logic [W-1:0] expq[$];
    int           phq[$];
    logic [W-1:0] logq[$];
    int           hi_run = 0;
    int           last_hi = 0;
    int           gap_run = 0;
    int           upulses = 0;
    logic [15:0]  fc_model = 16'd0;
    bit           rdy_toggle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // PHY side: tx_ready either always high or alternating every cycle.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) bus.tx_ready = ~bus.tx_ready;
            else bus.tx_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] expw;
        int           ph;
        if (reset) begin
            expq.delete();
            phq.delete();
            hi_run  = 0;
            gap_run = 0;
        end else if (bus.tx_request) begin
            hi_run++;
            check("busy_in_burst", bus.busy, 1);
            nchk++;
            if (expq.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_request: got tx_request=1 required 0 at %0t", $time);
            end else begin
                ph   = phq[0];
                expw = expq[0];
                if (bus.tx_ready) begin
                    check("tx_data", bus.tx_data, expw);
                    check("underrun", bus.underrun, (ph == 1) && !bus.s_valid);
                    check("s_ready_xfer", bus.s_ready, ph == 1);
                    if (bus.underrun) upulses++;
                    logq.push_back(bus.tx_data);
                    void'(expq.pop_front());
                    void'(phq.pop_front());
                end else begin
                    if (ph == 1) expw = bus.s_valid ? bus.s_data : '0;
                    check("tx_data_hold", bus.tx_data, expw);
                    check("s_ready_stall", bus.s_ready, 0);
                    check("underrun_stall", bus.underrun, 0);
                end
            end
        end else begin
            if (hi_run > 0) begin
                last_hi = hi_run;
                hi_run  = 0;
            end
            check("tx_data_quiet", bus.tx_data, 0);
            check("underrun_quiet", bus.underrun, 0);
            if (bus.busy) begin
                gap_run++;
                check("s_ready_gap", bus.s_ready, 0);
            end else begin
                if (gap_run > 0) begin
                    check("gap_len", gap_run, GAP);
                    gap_run = 0;
                end
                check("s_ready_idle", bus.s_ready, bus.s_valid && !bus.s_first);
            end
            if (phq.size() > 0 && phq[0] != 0) begin
                nchk++;
                nfail++;
                $display("FAIL request_dropped: got tx_request=0 required 1 at %0t", $time);
            end
        end
    end

    task automatic drive_beat(input int k, input int n);
        bus.s_valid = 1'b1;
        bus.s_first = (k == 0);
        bus.s_last  = (k == n - 1);
        bus.s_data  = {DPHY_LANES{8'(k + 1)}};
    endtask

    task automatic idle_inputs();
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = '0;
    endtask

    // Sends an n-beat frame; optional two-cycle stall after beat under_at, optional reset
    // once abort_at beats have been accepted.
    task automatic send_frame(input int n, input int under_at, input int abort_at);
        int   k;
        int   cyc;
        int   tcnt;
        logic acc;
        @(posedge clk);
        #1;
        logq.delete();
        expq.push_back((W'(fc_model) << 8) | W'(8'hA5));
        phq.push_back(0);
        tcnt = n;
        for (int i = 0; i < n; i++) begin
            expq.push_back({DPHY_LANES{8'(i + 1)}});
            phq.push_back(1);
            if (i == under_at) begin
                repeat (2) begin
                    expq.push_back('0);
                    phq.push_back(1);
                end
                tcnt += 2;
            end
        end
        expq.push_back(W'(tcnt));
        phq.push_back(2);

        k   = 0;
        cyc = 0;
        drive_beat(0, n);
        while (k < n && cyc < 400) begin
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                k++;
                if (k == abort_at) begin
                    reset = 1'b1;
                    idle_inputs();
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    @(negedge clk);
                    check("abort_tx_request", bus.tx_request, 0);
                    check("abort_frame_count", bus.frame_count, 0);
                    check("abort_busy", bus.busy, 0);
                    fc_model = 16'd0;
                    return;
                end
                if (k - 1 == under_at) begin
                    bus.s_valid = 1'b0;
                    repeat (2) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (k < n) drive_beat(k, n);
                else idle_inputs();
            end
        end
        check("beats_accepted", k, n);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.busy && cyc < 400);
        check("frame_done", bus.busy, 0);
        fc_model = fc_model + 16'd1;
        check("frame_count", bus.frame_count, fc_model);
    endtask

    initial begin
        logic [W-1:0] nom[6];
        int           nacc;
        nom = '{16'h00A5, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0004};
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_request", bus.tx_request, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_tx_data", bus.tx_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Nominal 4-beat burst with tx_ready held high.
        send_frame(4, -1, -1);
        check("nom_len", logq.size(), 6);
        for (int i = 0; i < 6; i++) check("nom_word", logq[i], nom[i]);
        check("nom_req_cycles", last_hi, 6);

        // Back-pressure: tx_ready alternating.
        rdy_toggle = 1'b1;
        send_frame(4, -1, -1);
        rdy_toggle = 1'b0;
        check("bp_len", logq.size(), 6);
        check("bp_trailer", logq[5], 16'h0004);

        // Underrun: two idle cycles after the second beat.
        upulses = 0;
        send_frame(4, 1, -1);
        check("ur_pulses", upulses, 2);
        check("ur_fill0", logq[3], 16'h0000);
        check("ur_fill1", logq[4], 16'h0000);
        check("ur_trailer", logq[7], 16'h0006);

        // Resync: three beats without s_first are swallowed in idle.
        nacc = 0;
        bus.s_valid = 1'b1;
        bus.s_first = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 16'hBEEF;
        repeat (3) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) nacc++;
            check("resync_no_req", bus.tx_request, 0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check("resync_accepted", nacc, 3);
        send_frame(4, -1, -1);
        check("resync_header", logq[0], 16'h03A5);
        check("resync_trailer", logq[5], 16'h0004);

        // Frame counter wrap.
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        fc_model = 16'hFFFF;
        send_frame(2, -1, -1);
        check("wrap_header", logq[0], 16'hFFA5);
        check("wrap_count", bus.frame_count, 16'h0000);
        send_frame(2, -1, -1);
        check("wrap_next_header", logq[0], 16'h00A5);

        // Reset in the middle of the payload abandons the burst.
        send_frame(4, -1, 2);
        repeat (3) begin
            @(negedge clk);
            check("post_abort_quiet", bus.tx_request, 0);
        end
        send_frame(3, -1, -1);
        check("post_abort_header", logq[0], 16'h00A5);
        check("post_abort_trailer", logq[4], 16'h0003);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nchk, nfail + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rtcl_hs_tx_framer.md
RTCL_HS_TX_FRAMER -- requirements
Module: rtcl_hs_tx_framer

Interface
REQ-001 SHALL have parameter DPHY_LANES, default 2, meaning number of HS data lanes; legal values are 2 or more.
REQ-002 SHALL have parameter GAP_CYCLES, default 8, meaning the minimum number of cycles with tx_request low between bursts; legal values are 1 or more.
REQ-003 SHALL define W = DPHY_LANES*8 as the data width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all logic.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 s_first  input  1  first beat of a frame.
REQ-007 s_last  input  1  last beat of a frame.
REQ-008 s_data  input  W  payload beat; lane n occupies bits [8n+7:8n].
REQ-009 s_valid  input  1  upstream beat valid.
REQ-010 s_ready  output  1  upstream beat accepted.
REQ-011 tx_request  output  1  HS request to the D-PHY TX (PPI TxRequestHS).
REQ-012 tx_ready  input  1  D-PHY has consumed tx_data this cycle (PPI TxReadyHS).
REQ-013 tx_data  output  W  HS data to the D-PHY TX.
REQ-014 frame_count  output  16  number of completed bursts, wrapping.
REQ-015 underrun  output  1  one-cycle pulse when a filler beat is sent.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, HEADER, PAYLOAD, TRAILER and GAP.
REQ-018 IDLE: when s_valid=1 and s_first=1, go to HEADER next cycle and do not accept the beat (s_ready=0).
REQ-019 IDLE: when s_valid=1 and s_first=0, accept the beat with s_ready=1 and discard it, which resynchronises to the next frame.
REQ-020 tx_request SHALL be registered, equal 1 in HEADER, PAYLOAD and TRAILER, and equal 0 in IDLE and GAP.
REQ-021 HEADER: tx_data = {frame_count zero-extended or truncated to W-8 bits, 8'hA5}; transition to PAYLOAD on the cycle where tx_ready=1.
REQ-022 PAYLOAD: s_ready = tx_ready, combinationally, so there are zero cycles of latency from s_data to tx_data.
REQ-023 PAYLOAD: tx_data = s_valid ? s_data : 0.
REQ-024 PAYLOAD with tx_ready=1 and s_valid=0: send a zero filler beat and pulse underrun for 1 cycle; the filler beat counts as a beat.
REQ-025 PAYLOAD: each cycle with tx_ready=1 increments the 16-bit beat counter, which wraps from 0xFFFF to 0.
REQ-026 PAYLOAD: an accepted beat with s_last=1 moves the state to TRAILER.
REQ-027 PAYLOAD: an accepted beat with s_first=1 is treated as ordinary payload and does not restart the frame.
REQ-028 PAYLOAD with tx_ready=0: hold state, tx_data tracks s_data, s_ready=0, and no counter changes.
REQ-029 TRAILER: tx_data = beat count zero-extended or truncated to W bits.
REQ-030 TRAILER: on tx_ready=1, go to GAP, increment frame_count (wrapping 0xFFFF to 0), and clear the beat counter.
REQ-031 GAP: hold for exactly GAP_CYCLES cycles, then go to IDLE; s_ready=0 throughout.
REQ-032 s_ready SHALL be 0 in HEADER, TRAILER and GAP.
REQ-033 tx_data SHALL be 0 in IDLE and GAP.
REQ-034 underrun SHALL never be asserted outside PAYLOAD.

Reset
REQ-035 While reset=1: state=IDLE, tx_request=0, frame_count=0, beat counter=0, gap counter=0, underrun=0, busy=0.
REQ-036 Reset mid-burst SHALL abandon the burst: tx_request=0 on the cycle after reset is sampled, and no trailer is sent.
REQ-037 After reset, the first accepted s_first starts a new frame, and its header carries frame_count 0.

Verification
REQ-038 Nominal burst: 4 beats 0x0101..0x0404 (last on 4th), tx_ready=1 from the first request cycle -> tx_data sequence 0x00A5, 0x0101, 0x0202, 0x0303, 0x0404, 0x0004; tx_request high for exactly 6 cycles, then low for 8 cycles; frame_count=1.
REQ-039 Back-pressure: tx_ready toggles 1/0 during payload -> no beat duplicated or lost, s_ready equals tx_ready, trailer=0x0004.
REQ-040 Underrun: s_valid dropped for 2 cycles mid-payload with tx_ready=1 -> two 0x0000 beats, two underrun pulses, trailer beat count +2.
REQ-041 Resync: 3 beats without first while IDLE -> all accepted and discarded, tx_request stays 0; the following frame is correct.
REQ-042 Wrap: preset 65535 frames (or force frame_count=0xFFFF) -> header 0xFFA5, then frame_count=0 and the next header 0x00A5.
REQ-043 Reset asserted during PAYLOAD -> tx_request=0 next cycle, frame_count=0, and a subsequent frame header=0x00A5.
